ring_client_port: RTL and testbench
===================================

// Module: ring_client_port
// PURPOSE
// Initiator-side client for one stop on the circular memory ring. It takes one read/write
// request at a time from a local unit and injects it into the first EMPTY slot passing
// the stop. It then removes the matching response (id == CLIENT_ID) from the ring and
// returns it to the local unit. Sits between a local unit and its ring stop's req-side ports.
// PARAMETERS
// DEPTH      512   ring data width in bits (matches ring stop)
// CLIENT_ID  5'd1  this client's ring id; nonzero, unique per ring
// TIMEOUT    1024  cycles in WAIT_RESP before an error completion; >= 1
// PORTS
// clk            in   1      clock
// rst            in   1      reset, asynchronous, active-low
// req_valid      in   1      local request valid
// req_ready      out  1      request accepted when valid&ready
// req_write      in   1      1 = write, 0 = read
// req_addr       in   36     request address
// req_data       in   DEPTH  write data; ignored for reads
// resp_valid     out  1      completion valid; held until resp_ready
// resp_ready     in   1      local unit accepts completion
// resp_data      out  DEPTH  read data; 0 for write-ack or error
// resp_err       out  1      completion is a timeout error
// stray_drop     out  1      1-cycle pulse: unexpected response for CLIENT_ID removed
// ring_addr_in   in   36     slot address from ring stop (stop's addr_req_out)
// ring_data_in   in   DEPTH  slot data from ring stop
// ring_id_in     in   5      slot id from ring stop
// ring_type_in   in   3      slot packet type from ring stop
// overwrite      out  1      replace the passing slot with ring_*_out
// ring_addr_out  out  36     to stop's addr_req_in
// ring_data_out  out  DEPTH  to stop's data_req_in
// ring_id_out    out  5      to stop's id_req_in
// ring_type_out  out  3      to stop's packet_type_req_in
// BEHAVIOUR
// - Packet types: EMPTY=0, RD_REQ=1, WR_REQ=2, RD_RESP=3, WR_ACK=4; 5-7 are reserved and passed untouched.
// - Request slots carry id = CLIENT_ID, meaning source. Response slots carry id = destination.
// - FSM IDLE -> INJECT -> WAIT_RESP -> DONE -> IDLE. All registers reset to IDLE with zeros.
// - Outputs in reset: req_ready=0, resp_valid=0, resp_err=0, resp_data=0, stray_drop=0, overwrite=0.
// - IDLE: req_ready=1. On req_valid, latch write/addr/data and go to INJECT.
//   req_ready=0 in every other state.
// - INJECT: if ring_type_in==EMPTY in this cycle, drive overwrite=1 combinationally.
//   ring_* = {req_addr, req_data (zeros for reads), CLIENT_ID, RD_REQ/WR_REQ}.
//   Go to WAIT_RESP next cycle. A non-EMPTY slot means wait; no overwrite.
// - WAIT_RESP: a match is ring_id_in==CLIENT_ID with ring_type_in==RD_RESP (read) or WR_ACK (write).
//   On a match: overwrite=1 with type EMPTY and id/addr/data 0, which removes the packet.
//   Latch ring_data_in (0 for WR_ACK) and go to DONE.
// - Timeout: counter clears on entering WAIT_RESP and increments each cycle there.
//   When it reaches TIMEOUT-1 with no match, go to DONE with resp_err=1 and resp_data=0.
//   A match in that same cycle wins; no error.
// - DONE: resp_valid=1 and stays held. On resp_ready, go to IDLE. There is no same-cycle IDLE accept.
// - Stray response: ring_id_in==CLIENT_ID, type RD_RESP/WR_ACK, not a match in WAIT_RESP.
//   This includes late responses after a timeout and wrong-kind responses.
//   Remove it (overwrite EMPTY) and pulse stray_drop the next cycle. This applies in any state.
//   Exception: in INJECT, if the passing slot is such a stray, removing it frees that slot.
//   Inject the pending request into it the same cycle instead of writing EMPTY, with no stray_drop.
// - Packets with other ids or request types are never overwritten (overwrite=0).
// - overwrite and ring_*_out are combinational from state and ring_*_in, with zero latency.
//   All other outputs are registered.
// - Asynchronous reset mid-transaction: return to IDLE and drop the pending request.
//   A later response for it is handled as a stray.
// STRUCTURE
// - ring_pkg: typedef enum logic[2:0] pkt_type_e {EMPTY,RD_REQ,WR_REQ,RD_RESP,WR_ACK},
//   ADDR_W=36 and ID_W=5, shared with ring stops and the memory-side responder.
// - Single module. FSM and timeout counter are inline; the timeout counter is $clog2(TIMEOUT+1) bits.
// TESTING
// 1 Read with the ring empty: request addr=36'h123 at t0.
//   -> overwrite at t1 with RD_REQ/id=CLIENT_ID.
//   Inject RD_RESP id=CLIENT_ID data=0xAB at t5 -> overwrite EMPTY at t5; resp_valid=1, resp_data=0xAB at t6.
// 2 Busy ring: slots WR_REQ id=7 for 3 cycles, then EMPTY.
//   -> overwrite=0 on those 3 cycles, injection on the 4th; foreign packets pass unmodified.
// 3 Write with TIMEOUT=8 and no response.
//   -> resp_valid with resp_err=1 after 8 WAIT_RESP cycles.
//   A later WR_ACK id=CLIENT_ID -> removed, stray_drop pulse.
// 4 Backpressure: hold resp_ready=0 for 10 cycles.
//   -> resp_valid/resp_data stable, req_ready=0; resp_ready=1 -> IDLE next cycle, req_ready=1.
// 5 A RD_RESP for id=3 passes during WAIT_RESP -> not removed.
//   A WR_ACK for CLIENT_ID during a pending read -> stray_drop; the read still completes later.
// 6 Assert rst in WAIT_RESP -> all outputs 0 immediately (async); clean IDLE after release.

Source files
------------

// File: rtl/ring_pkg.sv
// Shared ring definitions: packet types and field widths used by ring stops,
// initiator clients and the memory-side responder.
package ring_pkg;

    localparam int ADDR_W = 36;
    localparam int ID_W   = 5;

    typedef enum logic [2:0] {
        EMPTY   = 3'd0,
        RD_REQ  = 3'd1,
        WR_REQ  = 3'd2,
        RD_RESP = 3'd3,
        WR_ACK  = 3'd4
    } pkt_type_e;

    typedef enum logic [1:0] {
        IDLE,
        INJECT,
        WAIT_RESP,
        DONE
    } client_state_e;

    // Reserved types 5-7 are not responses and must never be removed.
    function automatic logic is_resp(input logic [2:0] pkt_type);
        return (pkt_type == RD_RESP) || (pkt_type == WR_ACK);
    endfunction

endpackage

// File: rtl/ring_client_port.sv
// Initiator-side ring client: injects one local request into the first free slot,
// then pulls its response off the ring and hands it back to the local unit.
module ring_client_port
    import ring_pkg::*;
#(
    parameter int              DEPTH     = 512,
    parameter logic [ID_W-1:0] CLIENT_ID = 5'd1,
    parameter int              TIMEOUT   = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DEPTH-1:0]    req_data,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [DEPTH-1:0]    resp_data,
    output logic                resp_err,
    output logic                stray_drop,
    input  logic [ADDR_W-1:0]   ring_addr_in,
    input  logic [DEPTH-1:0]    ring_data_in,
    input  logic [ID_W-1:0]     ring_id_in,
    input  logic [2:0]          ring_type_in,
    output logic                overwrite,
    output logic [ADDR_W-1:0]   ring_addr_out,
    output logic [DEPTH-1:0]    ring_data_out,
    output logic [ID_W-1:0]     ring_id_out,
    output logic [2:0]          ring_type_out
);

    localparam int              CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    client_state_e     state, state_n;
    logic              wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DEPTH-1:0]  data_q;
    logic [CNT_W-1:0]  cnt;

    logic own_resp;
    logic match;
    logic inject;
    logic stray;
    logic timed_out;

    // Slot classification; a response addressed to us is reusable as a free slot in INJECT.
    always_comb begin
        own_resp  = (ring_id_in == CLIENT_ID) && is_resp(ring_type_in);
        match     = (state == WAIT_RESP) && (ring_id_in == CLIENT_ID) &&
                    (wr_q ? (ring_type_in == WR_ACK) : (ring_type_in == RD_RESP));
        inject    = (state == INJECT) && ((ring_type_in == EMPTY) || own_resp);
        stray     = own_resp && !match && !inject;
        timed_out = (state == WAIT_RESP) && !match && (cnt == CNT_LAST);
    end

    // Untouched slots are echoed back; the stop only samples ring_*_out when overwrite=1.
    always_comb begin
        overwrite     = inject || match || stray;
        ring_addr_out = ring_addr_in;
        ring_data_out = ring_data_in;
        ring_id_out   = ring_id_in;
        ring_type_out = ring_type_in;
        if (inject) begin
            ring_addr_out = addr_q;
            ring_data_out = data_q;
            ring_id_out   = CLIENT_ID;
            ring_type_out = wr_q ? WR_REQ : RD_REQ;
        end else if (match || stray) begin
            ring_addr_out = '0;
            ring_data_out = '0;
            ring_id_out   = '0;
            ring_type_out = EMPTY;
        end
    end

    // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:      if (req_valid && req_ready) state_n = INJECT;
            INJECT:    if (inject)                 state_n = WAIT_RESP;
            WAIT_RESP: if (match || timed_out)     state_n = DONE;
            DONE:      if (resp_ready)             state_n = IDLE;
            default:                               state_n = IDLE;
        endcase
    end

    // NOTE: state is updated only with non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            cnt        <= '0;
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_err   <= 1'b0;
            stray_drop <= 1'b0;
        end else begin
            state      <= state_n;
            req_ready  <= (state_n == IDLE);
            resp_valid <= (state_n == DONE);
            stray_drop <= stray;
            unique case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        wr_q   <= req_write;
                        addr_q <= req_addr;
                        data_q <= req_write ? req_data : '0;
                    end
                end
                INJECT: cnt <= '0;
                WAIT_RESP: begin
                    cnt <= cnt + 1'b1;
                    if (match) begin
                        resp_data <= wr_q ? '0 : ring_data_in;
                        resp_err  <= 1'b0;
                    end else if (timed_out) begin
                        resp_data <= '0;
                        resp_err  <= 1'b1;
                    end
                end
                DONE: begin
                    if (resp_ready) begin
                        resp_data <= '0;
                        resp_err  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ring_client_port.sv
// Directed bench for ring_client_port: slot-classification table plus hand-timed
// read, write, busy-ring, timeout, backpressure, stray and reset sequences.
module tb_ring_client_port;
    import ring_pkg::*;

    localparam int              DEPTH   = 64;
    localparam logic [ID_W-1:0] CID     = 5'd1;
    localparam int              TIMEOUT = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid, req_ready, req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DEPTH-1:0]  req_data;
    logic              resp_valid, resp_ready, resp_err, stray_drop;
    logic [DEPTH-1:0]  resp_data;
    logic [ADDR_W-1:0] ring_addr_in, ring_addr_out;
    logic [DEPTH-1:0]  ring_data_in, ring_data_out;
    logic [ID_W-1:0]   ring_id_in, ring_id_out;
    logic [2:0]        ring_type_in, ring_type_out;
    logic              overwrite;

    int checks   = 0;
    int failures = 0;

    ring_client_port #(.DEPTH(DEPTH), .CLIENT_ID(CID), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_data(req_data),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_err(resp_err), .stray_drop(stray_drop),
        .ring_addr_in(ring_addr_in), .ring_data_in(ring_data_in),
        .ring_id_in(ring_id_in), .ring_type_in(ring_type_in),
        .overwrite(overwrite), .ring_addr_out(ring_addr_out),
        .ring_data_out(ring_data_out), .ring_id_out(ring_id_out),
        .ring_type_out(ring_type_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] typ;
        logic [4:0] id;
        logic       exp_ow;
        logic       exp_stray;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic slot(input logic [2:0] t, input logic [4:0] id, input logic [35:0] a,
                        input logic [63:0] d);
        ring_type_in = t;
        ring_id_in   = id;
        ring_addr_in = a;
        ring_data_in = d;
    endtask

    task automatic request(input logic wr, input logic [35:0] a, input logic [63:0] d);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_data  = d;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic ack();
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        req_valid = 0; req_write = 0; req_addr = '0; req_data = '0; resp_ready = 0;
        slot(3'd0, 5'd0, 36'h0, 64'h0);

        vecs[0] = '{3'd0, 5'd0,  1'b0, 1'b0};
        vecs[1] = '{3'd1, 5'd7,  1'b0, 1'b0};
        vecs[2] = '{3'd2, 5'd1,  1'b0, 1'b0};
        vecs[3] = '{3'd3, 5'd3,  1'b0, 1'b0};
        vecs[4] = '{3'd3, 5'd1,  1'b1, 1'b1};
        vecs[5] = '{3'd4, 5'd1,  1'b1, 1'b1};
        vecs[6] = '{3'd5, 5'd1,  1'b0, 1'b0};
        vecs[7] = '{3'd7, 5'd1,  1'b0, 1'b0};
        vecs[8] = '{3'd4, 5'd0,  1'b0, 1'b0};

        // Reset state
        #1 rst = 1'b0;
        #1;
        check("rst_req_ready",  64'(req_ready), 64'd0);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp_err",   64'(resp_err), 64'd0);
        check("rst_resp_data",  64'(resp_data), 64'd0);
        check("rst_stray_drop", 64'(stray_drop), 64'd0);
        check("rst_overwrite",  64'(overwrite), 64'd0);
        #21 rst = 1'b1;
        tick();

        // 1: read with empty ring, response 4 cycles after injection
        req_valid = 1; req_write = 0; req_addr = 36'h123; req_data = 64'hFFFF;
        @(negedge clk);
        check("t1_req_ready", 64'(req_ready), 64'd1);
        tick(); req_valid = 0;
        @(negedge clk);
        check("t1_inj_ow",   64'(overwrite), 64'd1);
        check("t1_inj_type", 64'(ring_type_out), 64'd1);
        check("t1_inj_id",   64'(ring_id_out), 64'(CID));
        check("t1_inj_addr", 64'(ring_addr_out), 64'h123);
        check("t1_inj_data", 64'(ring_data_out), 64'd0);
        check("t1_busy_ready", 64'(req_ready), 64'd0);
        tick();
        @(negedge clk);
        check("t1_wait_ow", 64'(overwrite), 64'd0);
        tick(); tick(); tick();
        slot(3'd3, CID, 36'h0, 64'hAB);
        @(negedge clk);
        check("t1_rm_ow",   64'(overwrite), 64'd1);
        check("t1_rm_type", 64'(ring_type_out), 64'd0);
        check("t1_rm_data", 64'(ring_data_out), 64'd0);
        check("t1_early_valid", 64'(resp_valid), 64'd0);
        tick();
        slot(3'd0, 5'd0, 36'h0, 64'h0);
        @(negedge clk);
        check("t1_resp_valid", 64'(resp_valid), 64'd1);
        check("t1_resp_data",  64'(resp_data), 64'hAB);
        check("t1_resp_err",   64'(resp_err), 64'd0);
        ack();
        @(negedge clk);
        check("t1_idle_valid", 64'(resp_valid), 64'd0);
        check("t1_idle_ready", 64'(req_ready), 64'd1);

        // 2: write on a busy ring, foreign response ignored, WR_ACK completes
        request(1'b1, 36'h456, 64'hDEAD);
        for (int i = 0; i < 3; i++) begin
            slot(3'd2, 5'd7, 36'h999, 64'h55);
            @(negedge clk);
            check("t2_busy_ow",   64'(overwrite), 64'd0);
            check("t2_busy_pass", 64'(ring_id_out), 64'd7);
            tick();
        end
        slot(3'd0, 5'd0, 36'h0, 64'h0);
        @(negedge clk);
        check("t2_inj_ow",   64'(overwrite), 64'd1);
        check("t2_inj_type", 64'(ring_type_out), 64'd2);
        check("t2_inj_addr", 64'(ring_addr_out), 64'h456);
        check("t2_inj_data", 64'(ring_data_out), 64'hDEAD);
        tick();
        slot(3'd3, 5'd3, 36'h0, 64'h99);
        @(negedge clk);
        check("t5_foreign_ow", 64'(overwrite), 64'd0);
        tick();
        check("t5_foreign_stray", 64'(stray_drop), 64'd0);
        slot(3'd4, CID, 36'h0, 64'h77);
        @(negedge clk);
        check("t2_ack_ow", 64'(overwrite), 64'd1);
        tick();
        slot(3'd0, 5'd0, 36'h0, 64'h0);
        @(negedge clk);
        check("t2_resp_valid", 64'(resp_valid), 64'd1);
        check("t2_resp_data",  64'(resp_data), 64'd0);
        check("t2_resp_err",   64'(resp_err), 64'd0);
        ack();

        // 5: stray in INJECT is reused, stray in WAIT_RESP dropped, read completes; 4: backpressure
        request(1'b0, 36'h10, 64'h0);
        slot(3'd4, CID, 36'h0, 64'h33);
        @(negedge clk);
        check("t5_reuse_ow",   64'(overwrite), 64'd1);
        check("t5_reuse_type", 64'(ring_type_out), 64'd1);
        check("t5_reuse_data", 64'(ring_data_out), 64'd0);
        tick();
        @(negedge clk);
        check("t5_reuse_nostray", 64'(stray_drop), 64'd0);
        check("t5_wrong_ow",   64'(overwrite), 64'd1);
        check("t5_wrong_type", 64'(ring_type_out), 64'd0);
        tick();
        slot(3'd0, 5'd0, 36'h0, 64'h0);
        @(negedge clk);
        check("t5_stray_pulse", 64'(stray_drop), 64'd1);
        check("t5_still_wait",  64'(resp_valid), 64'd0);
        tick();
        check("t5_stray_end", 64'(stray_drop), 64'd0);
        slot(3'd3, CID, 36'h0, 64'h5A);
        tick();
        slot(3'd0, 5'd0, 36'h0, 64'h0);
        @(negedge clk);
        check("t5_resp_data", 64'(resp_data), 64'h5A);
        for (int i = 0; i < 10; i++) begin
            tick();
            @(negedge clk);
            check("t4_hold_valid", 64'(resp_valid), 64'd1);
            check("t4_hold_data",  64'(resp_data), 64'h5A);
            check("t4_hold_ready", 64'(req_ready), 64'd0);
        end
        ack();
        @(negedge clk);
        check("t4_rel_valid", 64'(resp_valid), 64'd0);
        check("t4_rel_ready", 64'(req_ready), 64'd1);

        // 3: write timeout after TIMEOUT cycles in WAIT_RESP, then late ack is a stray
        request(1'b1, 36'h77, 64'h1234);
        tick();
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            if (resp_valid) break;
            tick();
            n++;
        end
        check("t3_timeout_cycles", 64'(n), 64'(TIMEOUT));
        check("t3_err",  64'(resp_err), 64'd1);
        check("t3_data", 64'(resp_data), 64'd0);
        ack();
        slot(3'd4, CID, 36'h0, 64'h0);
        @(negedge clk);
        check("t3_late_ow",   64'(overwrite), 64'd1);
        check("t3_late_type", 64'(ring_type_out), 64'd0);
        tick();
        slot(3'd0, 5'd0, 36'h0, 64'h0);
        check("t3_late_stray", 64'(stray_drop), 64'd1);

        // Match on the last timeout cycle wins over the error
        request(1'b0, 36'h88, 64'h0);
        tick();
        repeat (TIMEOUT - 1) tick();
        slot(3'd3, CID, 36'h0, 64'hC3);
        @(negedge clk);
        check("edge_ow", 64'(overwrite), 64'd1);
        tick();
        slot(3'd0, 5'd0, 36'h0, 64'h0);
        @(negedge clk);
        check("edge_valid", 64'(resp_valid), 64'd1);
        check("edge_err",   64'(resp_err), 64'd0);
        check("edge_data",  64'(resp_data), 64'hC3);
        ack();

        // Slot classification while IDLE
        for (int i = 0; i < 9; i++) begin
            slot(vecs[i].typ, vecs[i].id, 36'h5, 64'hF0);
            @(negedge clk);
            check($sformatf("tbl%0d_ow", i), 64'(overwrite), 64'(vecs[i].exp_ow));
            check($sformatf("tbl%0d_type", i), 64'(ring_type_out),
                  vecs[i].exp_ow ? 64'd0 : 64'(vecs[i].typ));
            tick();
            check($sformatf("tbl%0d_stray", i), 64'(stray_drop), 64'(vecs[i].exp_stray));
        end
        slot(3'd0, 5'd0, 36'h0, 64'h0);
        tick();

        // 6: async reset in WAIT_RESP, late response handled as stray
        request(1'b0, 36'h99, 64'h0);
        tick();
        slot(3'd4, CID, 36'h0, 64'h0);
        tick();
        slot(3'd0, 5'd0, 36'h0, 64'h0);
        check("t6_pre_stray", 64'(stray_drop), 64'd1);
        #2 rst = 1'b0;
        #1;
        check("t6_rst_stray", 64'(stray_drop), 64'd0);
        check("t6_rst_ready", 64'(req_ready), 64'd0);
        check("t6_rst_valid", 64'(resp_valid), 64'd0);
        check("t6_rst_ow",    64'(overwrite), 64'd0);
        #3 rst = 1'b1;
        tick();
        @(negedge clk);
        check("t6_idle_ready", 64'(req_ready), 64'd1);
        slot(3'd3, CID, 36'h0, 64'hEE);
        @(negedge clk);
        check("t6_late_ow", 64'(overwrite), 64'd1);
        tick();
        slot(3'd0, 5'd0, 36'h0, 64'h0);
        check("t6_late_stray", 64'(stray_drop), 64'd1);
        check("t6_late_valid", 64'(resp_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
